// File: rtl/shift_defs.sv
// Shared shifter definitions: FSM state codes and default datapath widths,
// reused by the left-shift and ALU blocks.
package shift_defs;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_SHAMT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage : shift_defs

// File: rtl/shift_right_seq.sv
// Iterative right shifter (SRL/SRA), one bit position per clock, with a
// start/busy/done handshake so a multi-cycle controller can stall on it.
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-low reset
//   start_i  : request; accepted in IDLE or DONE
//   data_i   : operand, captured on accept
//   shamt_i  : shift amount, captured on accept
//   arith_i  : 1 = sign fill (SRA), 0 = zero fill (SRL), captured on accept
//   busy_o   : high while shifting
//   done_o   : one-cycle pulse with the result valid
//   data_o   : result, held until the next accept
module shift_right_seq
    import shift_defs::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               arith_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [DATA_W-1:0]  data_o
);

    // One extra bit so the counter can hold DATA_W itself after clamping.
    localparam int unsigned CNT_W = SHAMT_W + 1;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fill_q, fill_d;
    logic               accept;

    // State, shift register, counter and fill bit
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        accept  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                accept  = start_i;
            end
            S_SHIFT: begin
                sh_d  = {fill_q, sh_q[DATA_W-1:1]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            sh_d   = data_i;
            fill_d = arith_i & data_i[DATA_W-1];
            // Shifting DATA_W times already gives all-fill; more is pointless.
            if (CNT_W'(shamt_i) >= CNT_W'(DATA_W)) begin
                cnt_d = CNT_W'(DATA_W);
            end else begin
                cnt_d = CNT_W'(shamt_i);
            end
            state_d = (shamt_i == '0) ? S_DONE : S_SHIFT;
        end
    end

    // Outputs are straight decodes of registered state
    assign busy_o = (state_q == S_SHIFT);
    assign done_o = (state_q == S_DONE);
    assign data_o = sh_q;

endmodule : shift_right_seq

// File: tb/tb_shift_right_seq.sv
// Directed-vector bench for shift_right_seq.
module tb_shift_right_seq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] data_i;
    logic [4:0]  shamt_i;
    logic        arith_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] data_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    shift_right_seq #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .data_i  (data_i),
        .shamt_i (shamt_i),
        .arith_i (arith_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .data_o  (data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 after the accept edge.
    task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic a);
        data_i  = d;
        shamt_i = s;
        arith_i = a;
        start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        data_i  = $urandom;
        shamt_i = 5'($urandom);
        arith_i = 1'($urandom);
    endtask

    // Waits for done (bounded), checking latency, busy cycles and result.
    // lat0 = cycles already elapsed since the accept edge (all of them busy).
    task automatic wait_check(input string tag, input int lat0, input int exp_lat,
                              input logic [31:0] exp_data);
        int lat   = lat0;
        int nbusy = lat0 - 1;
        int both  = 0;
        while (!done_o && lat < 200) begin
            if (busy_o) nbusy++;
            @(negedge clk_i);
            lat++;
        end
        if (busy_o && done_o) both++;
        check_vec({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_vec({tag, " busy cycles"}, 32'(nbusy), 32'(exp_lat - 1));
        check_vec({tag, " busy&done"}, 32'(both), 32'd0);
        check_vec({tag, " data"}, data_o, exp_data);
    endtask

    task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                          input logic a, input logic [31:0] exp_data);
        @(negedge clk_i);
        issue(d, s, a);
        wait_check(tag, 1, int'(s) + 1, exp_data);
    endtask

    initial begin
        int dones;
        rst_i   = 1'b0;
        start_i = 1'b0;
        data_i  = '0;
        shamt_i = '0;
        arith_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_vec("reset busy", 32'(busy_o), 32'd0);
        check_vec("reset done", 32'(done_o), 32'd0);
        check_vec("reset data", data_o, 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Reset during SHIFT discards the operation
        issue(32'h8000_0000, 5'd10, 1'b1);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        check_vec("midrst busy", 32'(busy_o), 32'd0);
        check_vec("midrst done", 32'(done_o), 32'd0);
        check_vec("midrst data", data_o, 32'd0);
        dones = 0;
        repeat (15) begin
            @(negedge clk_i);
            if (done_o || busy_o) dones++;
        end
        check_vec("midrst no activity", 32'(dones), 32'd0);

        // Plain SRL / SRA
        run_op("srl4", 32'hF000_0000, 5'd4, 1'b0, 32'h0F00_0000);
        @(negedge clk_i);
        check_vec("hold done", 32'(done_o), 32'd0);
        check_vec("hold busy", 32'(busy_o), 32'd0);
        check_vec("hold data", data_o, 32'h0F00_0000);
        run_op("sra4", 32'hF000_0000, 5'd4, 1'b1, 32'hFF00_0000);
        run_op("sra31", 32'hF000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);
        run_op("sra4pos", 32'h7000_0000, 5'd4, 1'b1, 32'h0700_0000);
        run_op("srl31", 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
        run_op("sh0", 32'h1234_5678, 5'd0, 1'b0, 32'h1234_5678);

        // start during SHIFT is ignored, operands not re-sampled
        @(negedge clk_i);
        issue(32'h0000_FF00, 5'd8, 1'b0);
        repeat (2) @(negedge clk_i);
        data_i  = 32'hFFFF_FFFF;
        shamt_i = 5'd1;
        arith_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_check("ignstart", 4, 9, 32'h0000_00FF);

        // Back-to-back: new start in the DONE cycle
        run_op("b2b first", 32'hF000_0000, 5'd4, 1'b0, 32'h0F00_0000);
        issue(32'h0000_0010, 5'd2, 1'b0);
        wait_check("b2b second", 1, 3, 32'h0000_0004);

        repeat (2) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_shift_right_seq
